// File: rtl/mau_ahb_split.sv
// mau_ahb_split: memory access unit between the load/store stage and an
// AHB-lite master port. Accepts one request per cycle over valid/ready and
// overlaps the address phase of the next transfer with the current data phase.
// Misaligned accesses are either split into byte beats or rejected with
// misaligned_exc. Load data is lane-selected and sign/zero extended to DW.
//
// Ports:
//   clk, reset            clock (HCLK) and async active-high reset
//   req_*                 request channel (valid/ready, store, size, addr, wdata, rd)
//   resp_*                completion pulse with rd, extended load data, bus error
//   misaligned_exc        accept-cycle pulse for misaligned access when not splitting
//   rs1_en/rs2_en, dec_*  decode operands, compared against the pending load rd
//   load_conflict         stall request to decode
//   H*                    AHB-lite master signals
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no data phase pending
// DATA  | single aligned transfer in data phase (or bus-less illegal access)
// SPLIT | byte-beat sequence, beat_q = 0..N-1, N = access bytes
module mau_ahb_split #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [4:0]    req_rd,
    output logic          resp_valid,
    output logic [4:0]    resp_rd,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    output logic          misaligned_exc,
    input  logic          rs1_en,
    input  logic          rs2_en,
    input  logic [4:0]    dec_rs1,
    input  logic [4:0]    dec_rs2,
    output logic          load_conflict,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic [1:0]    HRESP
);

    localparam int LW = (DW == 64) ? 3 : 2;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_SPLIT} state_t;

    state_t        state_q, state_d;
    logic          p_store_q, p_store_d;
    logic [2:0]    p_size_q, p_size_d;
    logic [AW-1:0] p_addr_q, p_addr_d;
    logic [4:0]    p_rd_q, p_rd_d;
    logic [DW-1:0] p_wdata_q, p_wdata_d;
    logic          p_nobus_q, p_nobus_d;
    logic [2:0]    beat_q, beat_d;
    logic [2:0]    nbeat_q, nbeat_d;
    logic [DW-1:0] buf_q, buf_d;
    logic [DW-1:0] hwdata_q, hwdata_d;

    logic [AW-1:0] beat_addr, next_addr;
    logic [2:0]    next_beat;
    logic [7:0]    rd_byte, wr_byte;
    logic [2:0]    r_mis_mask;
    logic          r_mis, r_illegal;
    logic          last, hresp_err, issue_ok, complete, cur_err;

    function automatic logic [DW-1:0] size_mask(input logic [1:0] sz);
        logic [DW-1:0] m;
        m = '0;
        case (sz)
            2'd0:    m[7:0]  = '1;
            2'd1:    m[15:0] = '1;
            2'd2:    m[31:0] = '1;
            default: m       = '1;
        endcase
        return m;
    endfunction

    // Low bits of raw hold the loaded value; size[2] selects zero extension.
    function automatic logic [DW-1:0] ld_extend(input logic [DW-1:0] raw, input logic [2:0] sz);
        logic [DW-1:0] m;
        logic          neg;
        m = size_mask(sz[1:0]);
        case (sz[1:0])
            2'd0:    neg = raw[7];
            2'd1:    neg = raw[15];
            2'd2:    neg = raw[31];
            default: neg = raw[DW-1];
        endcase
        return (raw & m) | ((!sz[2] && neg) ? ~m : '0);
    endfunction

    assign beat_addr = p_addr_q + AW'(beat_q);
    assign next_addr = beat_addr + {{(AW-1){1'b0}}, 1'b1};
    assign next_beat = beat_q + 3'd1;
    assign rd_byte   = HRDATA[{beat_addr[LW-1:0], 3'b000} +: 8];
    assign wr_byte   = p_wdata_q[{next_beat[LW-1:0], 3'b000} +: 8];
    assign last      = (beat_q == nbeat_q);
    assign hresp_err = (HRESP == RESP_ERR);

    always_comb begin
        case (req_size[1:0])
            2'd0:    r_mis_mask = 3'b000;
            2'd1:    r_mis_mask = 3'b001;
            2'd2:    r_mis_mask = 3'b011;
            default: r_mis_mask = 3'b111;
        endcase
    end

    assign r_mis     = |(req_addr[2:0] & r_mis_mask);
    assign r_illegal = (req_size == 3'b111) ||
                       ((DW == 32) && ((req_size == 3'b011) || (req_size == 3'b110)));

    assign HBURST        = 3'b000;
    assign HWDATA        = hwdata_q;
    assign load_conflict = ((state_q == S_DATA) || (state_q == S_SPLIT)) && !p_store_q &&
                           (p_rd_q != 5'd0) &&
                           ((rs1_en && (dec_rs1 == p_rd_q)) || (rs2_en && (dec_rs2 == p_rd_q)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            p_store_q <= 1'b0;
            p_size_q  <= 3'b000;
            p_addr_q  <= '0;
            p_rd_q    <= 5'd0;
            p_wdata_q <= '0;
            p_nobus_q <= 1'b0;
            beat_q    <= 3'd0;
            nbeat_q   <= 3'd0;
            buf_q     <= '0;
            hwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            p_store_q <= p_store_d;
            p_size_q  <= p_size_d;
            p_addr_q  <= p_addr_d;
            p_rd_q    <= p_rd_d;
            p_wdata_q <= p_wdata_d;
            p_nobus_q <= p_nobus_d;
            beat_q    <= beat_d;
            nbeat_q   <= nbeat_d;
            buf_q     <= buf_d;
            hwdata_q  <= hwdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        p_store_d = p_store_q;
        p_size_d  = p_size_q;
        p_addr_d  = p_addr_q;
        p_rd_d    = p_rd_q;
        p_wdata_d = p_wdata_q;
        p_nobus_d = p_nobus_q;
        beat_d    = beat_q;
        nbeat_d   = nbeat_q;
        buf_d     = buf_q;
        hwdata_d  = hwdata_q;

        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rd        = 5'd0;
        resp_data      = '0;
        resp_err       = 1'b0;
        misaligned_exc = 1'b0;
        HTRANS         = TR_IDLE;
        HADDR          = '0;
        HWRITE         = 1'b0;
        HSIZE          = 3'b000;
        issue_ok       = 1'b0;
        complete       = 1'b0;
        cur_err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                issue_ok  = 1'b1;
                req_ready = 1'b1;
            end
            S_DATA: begin
                // Illegal accesses sit here one cycle without a bus transfer.
                complete  = p_nobus_q || HREADY;
                cur_err   = p_nobus_q || (HREADY && hresp_err);
                issue_ok  = 1'b1;
                req_ready = complete;
                if (complete) begin
                    resp_valid = 1'b1;
                    resp_err   = cur_err;
                    resp_rd    = p_store_q ? 5'd0 : p_rd_q;
                    if (!cur_err && !p_store_q)
                        resp_data = ld_extend(HRDATA >> {beat_addr[LW-1:0], 3'b000}, p_size_q);
                    state_d = S_IDLE;
                end
            end
            S_SPLIT: begin
                issue_ok  = last;
                req_ready = last && HREADY;
                if (HREADY) begin
                    if (last || hresp_err) begin
                        resp_valid = 1'b1;
                        resp_err   = hresp_err;
                        resp_rd    = p_store_q ? 5'd0 : p_rd_q;
                        if (!hresp_err && !p_store_q)
                            resp_data = ld_extend(buf_q | ({{(DW-8){1'b0}}, rd_byte} << {beat_q[LW-1:0], 3'b000}),
                                                  p_size_q);
                        state_d = S_IDLE;
                    end else begin
                        beat_d = next_beat;
                        buf_d  = buf_q | ({{(DW-8){1'b0}}, rd_byte} << {beat_q[LW-1:0], 3'b000});
                        if (p_store_q)
                            hwdata_d = {{(DW-8){1'b0}}, wr_byte} << {next_addr[LW-1:0], 3'b000};
                    end
                end
                // Next beat overlaps this data phase; an error response (even its
                // first, not-ready cycle) withdraws it so no further beat is issued.
                if (!last && !hresp_err) begin
                    HTRANS = TR_NONSEQ;
                    HADDR  = next_addr;
                    HWRITE = p_store_q;
                    HSIZE  = 3'b000;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (req_valid && issue_ok) begin
            // Presented while the previous data phase may still be stalled; the
            // address phase completes together with req_ready.
            if (!r_illegal && !(r_mis && !SPLIT_MISALIGNED)) begin
                HTRANS = TR_NONSEQ;
                HADDR  = req_addr;
                HWRITE = req_store;
                HSIZE  = r_mis ? 3'b000 : {1'b0, req_size[1:0]};
            end
            if (req_ready) begin
                p_store_d = req_store;
                p_size_d  = req_size;
                p_addr_d  = req_addr;
                p_rd_d    = req_rd;
                p_wdata_d = req_wdata & size_mask(req_size[1:0]);
                p_nobus_d = 1'b0;
                beat_d    = 3'd0;
                nbeat_d   = r_mis_mask;
                buf_d     = '0;
                hwdata_d  = '0;
                if (r_illegal) begin
                    state_d   = S_DATA;
                    p_nobus_d = 1'b1;
                end else if (r_mis && !SPLIT_MISALIGNED) begin
                    misaligned_exc = 1'b1;
                    state_d        = S_IDLE;
                end else if (r_mis) begin
                    state_d = S_SPLIT;
                    if (req_store)
                        hwdata_d = {{(DW-8){1'b0}}, req_wdata[7:0]} << {req_addr[LW-1:0], 3'b000};
                end else begin
                    state_d = S_DATA;
                    if (req_store)
                        hwdata_d = (req_wdata & size_mask(req_size[1:0])) << {req_addr[LW-1:0], 3'b000};
                end
            end
        end
    end

endmodule

// File: tb/tb_mau_ahb_split.sv
module tb_mau_ahb_split;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_ns;
    logic        req_store;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rs1_en, rs2_en;
    logic [4:0]  dec_rs1, dec_rs2;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    logic        req_ready, resp_valid, resp_err, misaligned_exc, load_conflict, HWRITE;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;

    logic        ns_ready, ns_resp_valid, ns_resp_err, ns_exc, ns_conflict, ns_hwrite;
    logic [4:0]  ns_resp_rd;
    logic [31:0] ns_resp_data, ns_haddr, ns_hwdata;
    logic [1:0]  ns_htrans;
    logic [2:0]  ns_hsize, ns_hburst;

    always #5 clk = ~clk;

    mau_ahb_split #(.AW(32), .DW(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err),
        .misaligned_exc(misaligned_exc),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .load_conflict(load_conflict),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    mau_ahb_split #(.AW(32), .DW(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_ns), .req_ready(ns_ready), .req_store(req_store),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(ns_resp_valid), .resp_rd(ns_resp_rd), .resp_data(ns_resp_data),
        .resp_err(ns_resp_err), .misaligned_exc(ns_exc),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .load_conflict(ns_conflict),
        .HADDR(ns_haddr), .HTRANS(ns_htrans), .HWRITE(ns_hwrite), .HSIZE(ns_hsize),
        .HBURST(ns_hburst), .HWDATA(ns_hwdata), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        st;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] hrdata;
        logic [1:0]  trans;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic        eerr;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic err);
        exp_t e;
        e.rd = rd; e.data = data; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic settle();
        exp_t e;
        #1;
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_resp", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_resp_rd", resp_rd, e.rd);
                chk("sb_resp_data", resp_data, e.data);
                chk("sb_resp_err", resp_err, e.err);
            end
        end else begin
            chk("resp_data_zero_when_idle", resp_data, 0);
        end
    endtask

    task automatic drive_req(input logic st, input logic [2:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_store = st; req_size = sz;
        req_addr = addr; req_wdata = wd; req_rd = rd;
    endtask

    logic [31:0] hr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0; req_store = 1'b0;
        req_size = 3'b010; req_addr = '0; req_wdata = '0; req_rd = '0;
        rs1_en = 1'b0; rs2_en = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 2'b00;

        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        5'd3, 32'h8000_00F0, 2'b10, 3'b010, 32'h0,        5'd3, 32'h8000_00F0, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        5'd4, 32'h8000_0000, 2'b10, 3'b000, 32'h0,        5'd4, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        5'd4, 32'h8000_0000, 2'b10, 3'b000, 32'h0,        5'd4, 32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 5'd6, 32'h0,        2'b10, 3'b001, 32'hBEEF_0000, 5'd0, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        5'd7, 32'h8001_1234, 2'b10, 3'b001, 32'h0,        5'd7, 32'hFFFF_8001, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 32'h102, 32'h0,        5'd7, 32'h8001_1234, 2'b10, 3'b001, 32'h0,        5'd7, 32'h0000_8001, 1'b0};
        vecs[6]  = '{1'b1, 3'b000, 32'h101, 32'hFFFF_FFA5, 5'd1, 32'h0,        2'b10, 3'b000, 32'h0000_A500, 5'd0, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 5'd2, 32'h0,        2'b10, 3'b010, 32'hDEAD_BEEF, 5'd0, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 3'b000, 32'h100, 32'h0,        5'd9, 32'h1234_567F, 2'b10, 3'b000, 32'h0,        5'd9, 32'h0000_007F, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 32'h108, 32'h0,        5'd10, 32'h1111_1111, 2'b00, 3'b000, 32'h0,       5'd10, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 3'b110, 32'h104, 32'h0,        5'd11, 32'h2222_2222, 2'b00, 3'b000, 32'h0,       5'd11, 32'h0,        1'b1};

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_hburst", HBURST, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_conflict", load_conflict, 0);
        @(negedge clk);
        reset = 1'b0;

        // table-driven single transfers
        foreach (vecs[i]) begin
            drive_req(vecs[i].st, vecs[i].sz, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
            HREADY = 1'b1;
            settle();
            chk($sformatf("v%0d_ready", i), req_ready, 1);
            chk($sformatf("v%0d_htrans", i), HTRANS, vecs[i].trans);
            if (vecs[i].trans == 2'b10) begin
                chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].addr);
                chk($sformatf("v%0d_hsize", i), HSIZE, vecs[i].hsize);
                chk($sformatf("v%0d_hwrite", i), HWRITE, vecs[i].st);
            end
            push(vecs[i].erd, vecs[i].edata, vecs[i].eerr);
            @(negedge clk);
            req_valid = 1'b0;
            HRDATA = vecs[i].hrdata;
            settle();
            chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
            if (vecs[i].st) chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].hwdata);
            @(negedge clk);
        end

        // split misaligned LW with a queued request waiting for the final beat
        drive_req(1'b0, 3'b010, 32'h101, 32'h0, 5'd7);
        settle();
        chk("split_acc_htrans", HTRANS, 2'b10);
        chk("split_acc_haddr", HADDR, 32'h101);
        chk("split_acc_hsize", HSIZE, 3'b000);
        push(5'd7, 32'h4433_2211, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            logic [7:0] bv;
            bv = (k == 1) ? 8'h11 : (k == 2) ? 8'h22 : (k == 3) ? 8'h33 : 8'h44;
            hr = 32'hEEEE_EEEE;
            hr[((32'h101 + k - 1) % 4) * 8 +: 8] = bv;
            HRDATA = hr;
            drive_req(1'b0, 3'b010, 32'h200, 32'h0, 5'd8);
            settle();
            if (k < 4) begin
                chk($sformatf("split_b%0d_ready", k), req_ready, 0);
                chk($sformatf("split_b%0d_htrans", k), HTRANS, 2'b10);
                chk($sformatf("split_b%0d_haddr", k), HADDR, 32'h101 + k);
                chk($sformatf("split_b%0d_hsize", k), HSIZE, 3'b000);
                chk($sformatf("split_b%0d_resp", k), resp_valid, 0);
            end else begin
                chk("split_last_ready", req_ready, 1);
                chk("split_last_resp", resp_valid, 1);
                chk("split_next_haddr", HADDR, 32'h200);
                chk("split_next_hsize", HSIZE, 3'b010);
                push(5'd8, 32'h0102_0304, 1'b0);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        HRDATA = 32'h0102_0304;
        settle();
        chk("split_next_resp", resp_valid, 1);
        @(negedge clk);

        // misaligned with splitting disabled
        req_store = 1'b0; req_size = 3'b010; req_addr = 32'h101; req_rd = 5'd7;
        req_valid_ns = 1'b1;
        #1;
        chk("ns_ready", ns_ready, 1);
        chk("ns_exc", ns_exc, 1);
        chk("ns_htrans", ns_htrans, 2'b00);
        @(negedge clk);
        req_valid_ns = 1'b0;
        #1;
        chk("ns_exc_pulse", ns_exc, 0);
        chk("ns_no_resp", ns_resp_valid, 0);
        chk("ns_htrans_after", ns_htrans, 2'b00);
        @(negedge clk);
        #1;
        chk("ns_no_resp2", ns_resp_valid, 0);
        @(negedge clk);

        // back-to-back with a stalled first data phase
        drive_req(1'b1, 3'b010, 32'h10, 32'h1111_2222, 5'd0);
        settle();
        chk("b2b_sw_haddr", HADDR, 32'h10);
        chk("b2b_sw_hwrite", HWRITE, 1);
        push(5'd0, 32'h0, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            drive_req(1'b0, 3'b010, 32'h14, 32'h0, 5'd9);
            HREADY = 1'b0;
            settle();
            chk($sformatf("b2b_stall%0d_ready", c), req_ready, 0);
            chk($sformatf("b2b_stall%0d_htrans", c), HTRANS, 2'b10);
            chk($sformatf("b2b_stall%0d_haddr", c), HADDR, 32'h14);
            chk($sformatf("b2b_stall%0d_hwdata", c), HWDATA, 32'h1111_2222);
            chk($sformatf("b2b_stall%0d_resp", c), resp_valid, 0);
            @(negedge clk);
        end
        HREADY = 1'b1;
        settle();
        chk("b2b_go_ready", req_ready, 1);
        chk("b2b_go_resp", resp_valid, 1);
        chk("b2b_go_haddr", HADDR, 32'h14);
        push(5'd9, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        drive_req(1'b1, 3'b010, 32'h18, 32'h3333_4444, 5'd0);
        HRDATA = 32'hCAFE_F00D;
        settle();
        chk("b2b_ld_resp", resp_valid, 1);
        chk("b2b_sw2_haddr", HADDR, 32'h18);
        push(5'd0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        settle();
        chk("b2b_sw2_resp", resp_valid, 1);
        chk("b2b_sw2_hwdata", HWDATA, 32'h3333_4444);
        @(negedge clk);

        // load-use conflict
        dec_rs1 = 5'd5; rs1_en = 1'b1;
        drive_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        settle();
        chk("lc_accept", load_conflict, 0);
        push(5'd5, 32'h77, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; HREADY = 1'b0;
        settle();
        chk("lc_pending", load_conflict, 1);
        @(negedge clk);
        rs1_en = 1'b0; rs2_en = 1'b1; dec_rs2 = 5'd5;
        settle();
        chk("lc_rs2", load_conflict, 1);
        @(negedge clk);
        HREADY = 1'b1; HRDATA = 32'h77;
        settle();
        chk("lc_complete", load_conflict, 1);
        @(negedge clk);
        settle();
        chk("lc_after", load_conflict, 0);
        @(negedge clk);
        rs2_en = 1'b0; rs1_en = 1'b1; dec_rs1 = 5'd0;
        drive_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd0);
        settle();
        push(5'd0, 32'h66, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; HREADY = 1'b0;
        settle();
        chk("lc_rd0", load_conflict, 0);
        @(negedge clk);
        HREADY = 1'b1; HRDATA = 32'h66;
        settle();
        @(negedge clk);
        dec_rs1 = 5'd5;
        drive_req(1'b1, 3'b010, 32'h100, 32'h0, 5'd5);
        settle();
        push(5'd0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; HREADY = 1'b0;
        settle();
        chk("lc_store", load_conflict, 0);
        @(negedge clk);
        HREADY = 1'b1;
        settle();
        @(negedge clk);
        rs1_en = 1'b0;

        // bus error on beat 2 of a split SW
        drive_req(1'b1, 3'b010, 32'h101, 32'hA1B2_C3D4, 5'd0);
        settle();
        chk("err_acc_haddr", HADDR, 32'h101);
        push(5'd0, 32'h0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        settle();
        chk("err_b1_hwdata", HWDATA, 32'h0000_D400);
        chk("err_b1_haddr", HADDR, 32'h102);
        @(negedge clk);
        HREADY = 1'b0; HRESP = 2'b01;
        settle();
        chk("err_b2_hwdata", HWDATA, 32'h00C3_0000);
        chk("err_b2_cancel", HTRANS, 2'b00);
        @(negedge clk);
        HREADY = 1'b1;
        settle();
        chk("err_resp", resp_valid, 1);
        chk("err_htrans", HTRANS, 2'b00);
        @(negedge clk);
        HRESP = 2'b00;
        settle();
        chk("err_after_htrans", HTRANS, 2'b00);
        chk("err_after_ready", req_ready, 1);
        @(negedge clk);

        // error on a single transfer with a request accepted in the same cycle
        drive_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd11);
        settle();
        push(5'd11, 32'h0, 1'b1);
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h104, 32'h0, 5'd12);
        HRESP = 2'b01; HRDATA = 32'h9999_9999;
        settle();
        chk("errpipe_ready", req_ready, 1);
        chk("errpipe_haddr", HADDR, 32'h104);
        push(5'd12, 32'h55, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; HRESP = 2'b00; HRDATA = 32'h55;
        settle();
        chk("errpipe_resp2", resp_valid, 1);
        @(negedge clk);

        // reset in the middle of a split load (no response expected)
        dec_rs1 = 5'd7; rs1_en = 1'b1;
        drive_req(1'b0, 3'b010, 32'h101, 32'h0, 5'd7);
        #1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rstmid_conflict_before", load_conflict, 1);
        @(negedge clk);
        HREADY = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_htrans", HTRANS, 2'b00);
        chk("rstmid_haddr", HADDR, 0);
        chk("rstmid_hwdata", HWDATA, 0);
        chk("rstmid_resp", resp_valid, 0);
        chk("rstmid_conflict", load_conflict, 0);
        chk("rstmid_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0; HREADY = 1'b1; rs1_en = 1'b0;
        settle();
        chk("rstrel_ready", req_ready, 1);
        chk("rstrel_resp", resp_valid, 0);
        @(negedge clk);
        settle();
        chk("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
